// File: rtl/poly_stream_buffer.sv
// poly_stream_buffer: holds one N-coefficient, B-bit ring element.
//   Loads LANES coefficients per beat over a valid/ready input stream and
//   replays the stored polynomial non-destructively over a valid/ready
//   output stream, any number of times. The whole polynomial is exposed in
//   parallel on poly_reg, and range_err flags any loaded coefficient >= P.
// Ports:
//   clk, reset (async, active low)
//   wr_req / rd_req        : start a load / start a replay (sampled in IDLE)
//   in_valid/in_ready/in_data    : input beat stream, lane j at [j*B +: B]
//   out_valid/out_ready/out_data : output beat stream, same packing
//   out_last   : final beat of a replay
//   poly_valid : a complete polynomial is stored
//   range_err  : sticky out-of-range flag for the current load
//   busy       : not IDLE
//   poly_reg   : stored polynomial, coefficient i at [i*B +: B]

// Per-lane range checker: one coefficient against the modulus.
module poly_lane_rng #(
  parameter int unsigned B = 5,
  parameter int unsigned P = 17
) (
  input  logic [B-1:0] coef,
  output logic         oor
);
  assign oor = (32'(coef) >= P);
endmodule

module poly_stream_buffer #(
  parameter int unsigned P     = 17,
  parameter int unsigned N     = 8,
  parameter int unsigned B     = 5,
  parameter int unsigned LANES = 2,
  localparam int unsigned BEATS = N / LANES,
  localparam int unsigned CW    = $clog2(BEATS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_req,
  input  logic               rd_req,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*B-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*B-1:0] out_data,
  output logic               out_last,
  output logic               poly_valid,
  output logic               range_err,
  output logic               busy,
  output logic [N*B-1:0]     poly_reg
);

  typedef enum logic [1:0] {IDLE = 2'd0, STR = 2'd1, SND = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N*B-1:0] poly_q, poly_d;
  logic           pvalid_q, pvalid_d;
  logic           rerr_q, rerr_d;

  logic [LANES-1:0] lane_oor;
  logic [N*B-1:0]   shift_in, rot;
  logic             in_fire, out_fire, last_beat;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    poly_lane_rng #(.B(B), .P(P)) u_rng (
      .coef(in_data[j*B +: B]),
      .oor (lane_oor[j])
    );
  end

  // New beats enter at the top so that after BEATS beats the first beat
  // sits in the low lanes; replay rotates so the register ends unchanged.
  // With a single beat per polynomial both collapse to trivial forms.
  if (BEATS == 1) begin : g_one
    assign shift_in = in_data;
    assign rot      = poly_q;
  end else begin : g_multi
    assign shift_in = {in_data, poly_q[N*B-1:LANES*B]};
    assign rot      = {poly_q[LANES*B-1:0], poly_q[N*B-1:LANES*B]};
  end

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_beat = (cnt_q == CW'(BEATS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; read wins over write in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_req && pvalid_q) state_d = SND;
        else if (wr_req)        state_d = STR;
      end
      STR:     if (in_fire && last_beat)  state_d = IDLE;
      SND:     if (out_fire && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state_q == STR);
    out_valid = (state_q == SND);
    out_last  = (state_q == SND) && last_beat;
    busy      = (state_q != IDLE);
  end

  // Datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    poly_d   = poly_q;
    pvalid_d = pvalid_q;
    rerr_d   = rerr_q;
    case (state_q)
      IDLE: begin
        if (rd_req && pvalid_q) begin
          cnt_d = '0;
        end else if (wr_req) begin
          cnt_d    = '0;
          poly_d   = '0;
          pvalid_d = 1'b0;
          rerr_d   = 1'b0;
        end
      end
      STR: begin
        if (in_fire) begin
          poly_d = shift_in;
          cnt_d  = cnt_q + CW'(1);
          rerr_d = rerr_q | (|lane_oor);
          if (last_beat) pvalid_d = 1'b1;
        end
      end
      SND: begin
        if (out_fire) begin
          poly_d = rot;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      poly_q   <= '0;
      pvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      poly_q   <= poly_d;
      pvalid_q <= pvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign out_data   = poly_q[LANES*B-1:0];
  assign poly_reg   = poly_q;
  assign poly_valid = pvalid_q;
  assign range_err  = rerr_q;

endmodule
